// File: rtl/setup_ctrl_if.sv
// rtl/setup_ctrl_if.sv - Signal bundle between setup_ctrl and its surroundings
//
// Purpose : groups the enter key, setup-register readback, game FSM handshake
//           and the status/control outputs of setup_ctrl.
// Signals : enter      - debounced enter-key level
//           setup_in   - setup register contents [1:0] speed, [3:2] mode, [7:4] length
//           game_over  - one-cycle pulse from the game FSM
//           E          - setup register load enable
//           start      - one-cycle pulse releasing the game FSM
//           ready      - high while waiting for confirmation
//           busy       - high while the game runs
//           error      - high while the captured setup is rejected
//           state      - encoded controller state
// Modports: master - the controller (setup_ctrl)
//           slave  - the environment (button, setup register, game FSM)

interface setup_ctrl_if;
    logic       enter;
    logic [7:0] setup_in;
    logic       game_over;
    logic       E;
    logic       start;
    logic       ready;
    logic       busy;
    logic       error;
    logic [2:0] state;

    modport master (
        input  enter,
        input  setup_in,
        input  game_over,
        output E,
        output start,
        output ready,
        output busy,
        output error,
        output state
    );

    modport slave (
        output enter,
        output setup_in,
        output game_over,
        input  E,
        input  start,
        input  ready,
        input  busy,
        input  error,
        input  state
    );
endinterface

// File: rtl/setup_ctrl.sv
// rtl/setup_ctrl.sv - Game-configuration sequencer: load, validate, confirm, start
//
// Purpose : detects enter presses, pulses the setup register load enable,
//           validates the captured configuration and releases the game
//           datapath with a single start pulse.
// Ports   : clk  - system clock, rising edge
//           R    - asynchronous active-low reset
//           bus  - setup_ctrl_if.master (enter, setup_in, game_over in;
//                  E, start, ready, busy, error, state out)
// Params  : TIMEOUT - cycles allowed in CONFIRM before abandoning (>= 2)
// Options : SETUP_TIMEOUT_EN - when defined, CONFIRM gives up after TIMEOUT
//           cycles; when undefined no counter exists and CONFIRM waits forever.

module setup_ctrl #(
    parameter int TIMEOUT = 250_000_000
) (
    input  logic          clk,
    input  logic          R,
    setup_ctrl_if.master  bus
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD    = 3'd1,
        CHECK   = 3'd2,
        CONFIRM = 3'd3,
        RUN     = 3'd4,
        ERR     = 3'd5
    } state_t;

    state_t state_q;
    state_t state_d;

    logic enter_q;
    logic enter_edge;
    logic setup_ok;
    logic expired;

    logic e_q;
    logic start_q;
    logic ready_q;
    logic busy_q;
    logic error_q;

    // enter_q resets high so a key held through reset release is not a press.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            enter_q <= 1'b1;
        end else begin
            enter_q <= bus.enter;
        end
    end

    assign enter_edge = bus.enter & ~enter_q;

    // A zero sequence length or the reserved speed code is unplayable.
    assign setup_ok = (bus.setup_in[7:4] != 4'd0) && (bus.setup_in[1:0] != 2'b11);

`ifdef SETUP_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT);

    logic [CNT_W-1:0] cnt_q;

    assign expired = (cnt_q == CNT_W'(TIMEOUT - 1));

    // Counts only while staying in CONFIRM; any other path forces zero, which
    // also clears it on the way in from CHECK.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            cnt_q <= '0;
        end else if (state_q == CONFIRM && state_d == CONFIRM) begin
            if (!(&cnt_q)) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else begin
            cnt_q <= '0;
        end
    end
`else
    assign expired = 1'b0;
`endif

    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (enter_edge) begin
                    state_d = LOAD;
                end
            end
            LOAD: begin
                state_d = CHECK;
            end
            CHECK: begin
                state_d = setup_ok ? CONFIRM : ERR;
            end
            CONFIRM: begin
                // A press in the expiry cycle still starts the game.
                if (enter_edge) begin
                    state_d = RUN;
                end else if (expired) begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                if (bus.game_over) begin
                    state_d = IDLE;
                end
            end
            ERR: begin
                if (enter_edge) begin
                    state_d = LOAD;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are flops loaded from the next-state decode, so they line up
    // with the state register and carry no combinational path to the pins.
    always_ff @(posedge clk or negedge R) begin
        if (!R) begin
            e_q     <= 1'b0;
            start_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            e_q     <= (state_d == LOAD);
            start_q <= (state_q == CONFIRM) && (state_d == RUN);
            ready_q <= (state_d == CONFIRM);
            busy_q  <= (state_d == RUN);
            error_q <= (state_d == ERR);
        end
    end

    assign bus.E     = e_q;
    assign bus.start = start_q;
    assign bus.ready = ready_q;
    assign bus.busy  = busy_q;
    assign bus.error = error_q;
    assign bus.state = state_q;

endmodule

// File: tb/tb_setup_ctrl.sv
// tb/tb_setup_ctrl.sv - Directed scoreboard bench for setup_ctrl

module tb_setup_ctrl;

    logic clk = 1'b0;
    logic rst_n = 1'b0;

    int n_assert = 0;
    int n_fail   = 0;

    typedef struct {
        string      tag;
        logic [7:0] val;
    } exp_t;

    exp_t sb[$];

    setup_ctrl_if bus ();

    setup_ctrl #(.TIMEOUT(20)) dut (
        .clk (clk),
        .R   (rst_n),
        .bus (bus)
    );

    always #5 clk = ~clk;

    // Observed word: {E, start, ready, busy, error, state[2:0]}
    logic [7:0] obs;
    assign obs = {bus.E, bus.start, bus.ready, bus.busy, bus.error, bus.state};

    localparam logic [7:0] O_IDLE    = 8'h00;
    localparam logic [7:0] O_LOAD    = 8'h81;
    localparam logic [7:0] O_CHECK   = 8'h02;
    localparam logic [7:0] O_CONFIRM = 8'h23;
    localparam logic [7:0] O_START   = 8'h54;
    localparam logic [7:0] O_RUN     = 8'h14;
    localparam logic [7:0] O_ERR     = 8'h0D;

    task automatic push(input string tag, input logic [7:0] val);
        exp_t e;
        e.tag = tag;
        e.val = val;
        sb.push_back(e);
    endtask

    task automatic pop_check();
        exp_t e;
        n_assert++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty observed=%h required=entry", obs);
        end else begin
            e = sb.pop_front();
            assert (obs === e.val) else begin
                n_fail++;
                $error("FAIL %s observed=%h required=%h", e.tag, obs, e.val);
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic step(input string tag, input logic [7:0] val);
        push(tag, val);
        tick();
        pop_check();
    endtask

    // Pulse rules: E and start never together, neither held two cycles.
    logic e_prev = 1'b0;
    logic s_prev = 1'b0;
    always @(negedge clk) begin
        if (rst_n) begin
            n_assert++;
            assert (!(bus.E && bus.start) && !(bus.E && e_prev) && !(bus.start && s_prev)) else begin
                n_fail++;
                $error("FAIL pulse_rule observed E=%b start=%b prevE=%b prevS=%b required=no overlap/repeat",
                       bus.E, bus.start, e_prev, s_prev);
            end
        end
        e_prev = bus.E;
        s_prev = bus.start;
    end

    task automatic to_confirm(input logic [7:0] cfg);
        bus.setup_in = cfg;
        bus.enter = 1'b1;
        step("load", O_LOAD);
        bus.enter = 1'b0;
        step("check", O_CHECK);
        step("confirm", O_CONFIRM);
    endtask

    initial begin
        bus.enter     = 1'b1;
        bus.setup_in  = 8'h52;
        bus.game_over = 1'b0;

        // Reset with enter held, then release: no load pulse.
        tick();
        tick();
        push("reset", O_IDLE);
        pop_check();
        rst_n = 1'b1;
        step("held_enter_0", O_IDLE);
        step("held_enter_1", O_IDLE);
        step("held_enter_2", O_IDLE);
        bus.enter = 1'b0;
        step("release_enter", O_IDLE);

        // Valid flow
        to_confirm(8'h52);
        for (int i = 0; i < 4; i++) step("confirm_wait", O_CONFIRM);
        bus.enter = 1'b1;
        step("start", O_START);
        bus.enter = 1'b0;
        step("run", O_RUN);
        bus.enter = 1'b1;
        step("run_enter_ignored", O_RUN);
        step("run_enter_held", O_RUN);
        bus.enter = 1'b0;
        bus.game_over = 1'b1;
        step("game_over", O_IDLE);
        bus.game_over = 1'b0;
        step("idle_after", O_IDLE);

        // Invalid length, then retry with valid switches
        bus.setup_in = 8'h05;
        bus.enter = 1'b1;
        step("bad_len_load", O_LOAD);
        bus.enter = 1'b0;
        step("bad_len_check", O_CHECK);
        step("bad_len_err", O_ERR);
        step("bad_len_err_hold", O_ERR);
        to_confirm(8'h15);
        bus.enter = 1'b1;
        step("retry_start", O_START);
        bus.enter = 1'b0;
        bus.game_over = 1'b1;
        step("retry_over", O_IDLE);
        bus.game_over = 1'b0;

        // Reserved speed
        bus.setup_in = 8'h13;
        bus.enter = 1'b1;
        step("bad_speed_load", O_LOAD);
        bus.enter = 1'b0;
        step("bad_speed_check", O_CHECK);
        step("bad_speed_err", O_ERR);

        // Retry from ERR, then async reset in CONFIRM
        to_confirm(8'h52);
        #2 rst_n = 1'b0;
        #1;
        push("async_reset_confirm", O_IDLE);
        pop_check();
        tick();
        rst_n = 1'b1;
        step("after_reset_confirm", O_IDLE);

`ifdef SETUP_TIMEOUT_EN
        to_confirm(8'h52);
        for (int i = 1; i < 20; i++) step("timeout_wait", O_CONFIRM);
        step("timeout_expire", O_IDLE);
        to_confirm(8'h52);
        for (int i = 1; i < 20; i++) step("late_wait", O_CONFIRM);
        bus.enter = 1'b1;
        step("enter_beats_expiry", O_START);
`else
        to_confirm(8'h52);
        for (int i = 0; i < 30; i++) step("no_timeout_wait", O_CONFIRM);
        bus.enter = 1'b1;
        step("late_start", O_START);
`endif

        // game_over with enter rising together in RUN
        bus.enter = 1'b0;
        step("run_again", O_RUN);
        bus.enter = 1'b1;
        bus.game_over = 1'b1;
        step("over_with_enter", O_IDLE);
        bus.game_over = 1'b0;
        step("no_load_after_over", O_IDLE);
        step("no_load_after_over2", O_IDLE);
        bus.enter = 1'b0;

        // Async reset in RUN
        tick();
        to_confirm(8'h52);
        bus.enter = 1'b1;
        step("run_start", O_START);
        bus.enter = 1'b0;
        step("run_body", O_RUN);
        #2 rst_n = 1'b0;
        #1;
        push("async_reset_run", O_IDLE);
        pop_check();
        tick();
        rst_n = 1'b1;
        step("after_reset_run", O_IDLE);

        n_assert++;
        assert (sb.size() == 0) else begin
            n_fail++;
            $error("FAIL scoreboard_leftover observed=%0d required=0", sb.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
